// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared types, width helpers and clamp for the PID rate controller
package pid_pkg;

    // Control-update sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_MAC0    = 3'd2,
        ST_MAC1    = 3'd3,
        ST_MAC2    = 3'd4,
        ST_UPDATE  = 3'd5
    } pid_state_e;

    // Accumulator operations of the shared multiply-accumulate unit
    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_LOAD = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_SUB  = 2'd3
    } mac_op_e;

    // Error is sp - enc, so one extra bit carries the sign
    function automatic int err_w(input int dw);
        return dw + 1;
    endfunction

    // A = KP+KI+KD and B = KP+2*KD both stay below 4*2^GW
    function automatic int coeff_w(input int gw);
        return gw + 2;
    endfunction

    // |A*e0| + |B*e1| + |KD*e2| < 7 * 2^(DW+GW), plus sign and margin
    function automatic int acc_w(input int dw, input int gw);
        return dw + gw + 5;
    endfunction

    // Saturate a signed value into [0, hi]
    function automatic logic signed [63:0] clamp_range(input logic signed [63:0] v,
                                                       input logic signed [63:0] hi);
        if (v < 64'sd0) begin
            return 64'sd0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_mac.sv
// rtl/pid_mac.sv - single signed multiplier with add/subtract accumulator
import pid_pkg::*;

module pid_mac #(
    parameter int EW = 9,
    parameter int CW = 10,
    parameter int AW = 21
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    input  logic [1:0]           op_i,
    input  logic signed [EW-1:0] err_i,
    input  logic [CW-1:0]        coef_i,
    output logic signed [AW-1:0] acc_o
);

    localparam int PW = EW + CW + 1;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;

    // Coefficients are unsigned: zero-extend before the signed multiply
    always_comb begin
        prod     = PW'(err_i) * PW'($signed({1'b0, coef_i}));
        prod_ext = AW'(prod);
    end

    // Next accumulator value; clear wins over any operation
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else begin
            case (mac_op_e'(op_i))
                MAC_LOAD: acc_d = prod_ext;
                MAC_ADD:  acc_d = acc_q + prod_ext;
                MAC_SUB:  acc_d = acc_q - prod_ext;
                default:  acc_d = acc_q;
            endcase
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pid_rate_ctrl.sv
// rtl/pid_rate_ctrl.sv - incremental PID speed controller driving the PWM duty
import pid_pkg::*;

module pid_rate_ctrl #(
    parameter int DW      = 8,
    parameter int GW      = 8,
    parameter int OW      = 8,
    parameter int OUT_MAX = 2**OW - 1,
    parameter int FRAC    = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SAMPLE,
    input  logic          SP_VALID,
    input  logic [DW-1:0] SET_POINT,
    input  logic [DW-1:0] ENC_VAL,
    input  logic [GW-1:0] KP,
    input  logic [GW-1:0] KI,
    input  logic [GW-1:0] KD,
    input  logic          CLEAR,
    output logic [OW-1:0] PWM_VAL,
    output logic          DONE,
    output logic          BUSY,
    output logic          SAT_HI,
    output logic          SAT_LO,
    output logic          OVERRUN
);

    localparam int EW = err_w(DW);
    localparam int CW = coeff_w(GW);
    localparam int AW = acc_w(DW, GW);

    pid_state_e state_q;
    pid_state_e state_d;

    logic [DW-1:0]        sp_hold_q;
    logic [DW-1:0]        enc_q;
    logic [GW-1:0]        kp_q;
    logic [GW-1:0]        ki_q;
    logic [GW-1:0]        kd_q;
    logic [CW-1:0]        a_q;
    logic [CW-1:0]        b_q;
    logic signed [EW-1:0] e0_q;
    logic signed [EW-1:0] e1_q;
    logic signed [EW-1:0] e2_q;
    logic [OW-1:0]        pwm_q;
    logic                 done_q;
    logic                 sat_hi_q;
    logic                 sat_lo_q;
    logic                 ovr_q;

    logic                 busy;
    logic                 mac_clr;
    logic [1:0]           mac_op;
    logic signed [EW-1:0] mac_err;
    logic [CW-1:0]        mac_coef;
    logic signed [AW-1:0] acc;

    logic signed [AW-1:0] du;
    logic signed [AW:0]   u;
    logic [OW-1:0]        pwm_d;
    logic                 sat_hi_d;
    logic                 sat_lo_d;

    // Sequencer state register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fixed walk through the three MAC steps, CLEAR aborts
    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = SAMPLE ? ST_CAPTURE : ST_IDLE;
                ST_CAPTURE: state_d = ST_MAC0;
                ST_MAC0:    state_d = ST_MAC1;
                ST_MAC1:    state_d = ST_MAC2;
                ST_MAC2:    state_d = ST_UPDATE;
                ST_UPDATE:  state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Per-state MAC operand selection and busy indication
    always_comb begin
        busy     = (state_q != ST_IDLE);
        mac_clr  = CLEAR;
        mac_op   = MAC_HOLD;
        mac_err  = e0_q;
        mac_coef = a_q;
        case (state_q)
            ST_CAPTURE: mac_clr = 1'b1;
            ST_MAC0: begin
                mac_op   = MAC_ADD;
                mac_err  = e0_q;
                mac_coef = a_q;
            end
            ST_MAC1: begin
                mac_op   = MAC_SUB;
                mac_err  = e1_q;
                mac_coef = b_q;
            end
            ST_MAC2: begin
                mac_op   = MAC_ADD;
                mac_err  = e2_q;
                mac_coef = CW'(kd_q);
            end
            default: ;
        endcase
    end

    pid_mac #(
        .EW(EW),
        .CW(CW),
        .AW(AW)
    ) u_mac (
        .clk_i  (CLK),
        .rstn_i (RST),
        .clr_i  (mac_clr),
        .op_i   (mac_op),
        .err_i  (mac_err),
        .coef_i (mac_coef),
        .acc_o  (acc)
    );

    // New duty: scaled delta added to held duty, then clamped into the PWM range
    always_comb begin
        du       = acc >>> FRAC;
        u        = (AW+1)'(du) + (AW+1)'($signed({1'b0, pwm_q}));
        sat_lo_d = (u < 0);
        sat_hi_d = (u > (AW+1)'(OUT_MAX));
        pwm_d    = OW'(clamp_range(64'(u), 64'(OUT_MAX)));
    end

    // Operand capture, error history, duty and status registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sp_hold_q <= '0;
            enc_q     <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            e0_q      <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            pwm_q     <= '0;
            done_q    <= 1'b0;
            sat_hi_q  <= 1'b0;
            sat_lo_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (CLEAR) begin
            e0_q     <= '0;
            e1_q     <= '0;
            e2_q     <= '0;
            pwm_q    <= '0;
            done_q   <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= SAMPLE && busy;
            case (state_q)
                ST_IDLE: begin
                    if (SAMPLE) begin
                        enc_q <= ENC_VAL;
                        kp_q  <= KP;
                        ki_q  <= KI;
                        kd_q  <= KD;
                        if (SP_VALID) begin
                            sp_hold_q <= SET_POINT;
                        end
                    end
                end
                ST_CAPTURE: begin
                    e2_q <= e1_q;
                    e1_q <= e0_q;
                    e0_q <= $signed({1'b0, sp_hold_q}) - $signed({1'b0, enc_q});
                    a_q  <= CW'(kp_q) + CW'(ki_q) + CW'(kd_q);
                    b_q  <= CW'(kp_q) + (CW'(kd_q) << 1);
                end
                ST_UPDATE: begin
                    pwm_q    <= pwm_d;
                    sat_hi_q <= sat_hi_d;
                    sat_lo_q <= sat_lo_d;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PWM_VAL = pwm_q;
    assign DONE    = done_q;
    assign BUSY    = busy;
    assign SAT_HI  = sat_hi_q;
    assign SAT_LO  = sat_lo_q;
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_pid_rate_ctrl.sv
// tb/tb_pid_rate_ctrl.sv - directed self-checking bench for pid_rate_ctrl
module tb_pid_rate_ctrl;

    logic       CLK;
    logic       RST;
    logic       SAMPLE;
    logic       SP_VALID;
    logic [7:0] SET_POINT;
    logic [7:0] ENC_VAL;
    logic [7:0] KP;
    logic [7:0] KI;
    logic [7:0] KD;
    logic       CLEAR;

    logic [7:0] pwm0;
    logic       done0, busy0, hi0, lo0, ovr0;
    logic [7:0] pwm1;
    logic       done1, busy1, hi1, lo1, ovr1;

    int tests_run = 0;
    int failed    = 0;

    pid_rate_ctrl dut0 (
        .CLK(CLK), .RST(RST), .SAMPLE(SAMPLE), .SP_VALID(SP_VALID),
        .SET_POINT(SET_POINT), .ENC_VAL(ENC_VAL), .KP(KP), .KI(KI), .KD(KD),
        .CLEAR(CLEAR), .PWM_VAL(pwm0), .DONE(done0), .BUSY(busy0),
        .SAT_HI(hi0), .SAT_LO(lo0), .OVERRUN(ovr0)
    );

    pid_rate_ctrl #(.FRAC(2)) dut1 (
        .CLK(CLK), .RST(RST), .SAMPLE(SAMPLE), .SP_VALID(SP_VALID),
        .SET_POINT(SET_POINT), .ENC_VAL(ENC_VAL), .KP(KP), .KI(KI), .KD(KD),
        .CLEAR(CLEAR), .PWM_VAL(pwm1), .DONE(done1), .BUSY(busy1),
        .SAT_HI(hi1), .SAT_LO(lo1), .OVERRUN(ovr1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        tick();
    endtask

    // Issue one accepted sample, scramble inputs afterwards, wait for DONE
    task automatic run_update(input string tag, input logic [7:0] sp, input logic spv,
                              input logic [7:0] enc, input logic [7:0] kp,
                              input logic [7:0] ki, input logic [7:0] kd);
        int n;
        SET_POINT = sp; SP_VALID = spv; ENC_VAL = enc;
        KP = kp; KI = ki; KD = kd;
        SAMPLE = 1'b1;
        tick();
        SAMPLE = 1'b0;
        SET_POINT = 8'h55; ENC_VAL = 8'hAA; SP_VALID = 1'b1;
        KP = 8'hFF; KI = 8'hFF; KD = 8'hFF;
        check_eq({tag, "_busy"}, 32'(busy0), 32'd1);
        n = 0;
        while (!done0 && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd5);
    endtask

    initial begin
        bit seen;
        RST = 1'b0; SAMPLE = 1'b0; SP_VALID = 1'b0; SET_POINT = '0; ENC_VAL = '0;
        KP = '0; KI = '0; KD = '0; CLEAR = 1'b0;
        repeat (3) tick();
        check_eq("rst_pwm", 32'(pwm0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_sat_hi", 32'(hi0), 32'd0);
        check_eq("rst_sat_lo", 32'(lo0), 32'd0);
        check_eq("rst_overrun", 32'(ovr0), 32'd0);
        RST = 1'b1;
        tick();

        // Proportional only
        run_update("p1", 8'd100, 1'b1, 8'd0, 8'd1, 8'd0, 8'd0);
        check_eq("p1_pwm", 32'(pwm0), 32'd100);
        check_eq("p1_sat_hi", 32'(hi0), 32'd0);
        check_eq("p1_sat_lo", 32'(lo0), 32'd0);
        check_eq("p1_frac_pwm", 32'(pwm1), 32'd25);
        tick();
        check_eq("p1_done_once", 32'(done0), 32'd0);
        run_update("p2", 8'd100, 1'b1, 8'd60, 8'd1, 8'd0, 8'd0);
        check_eq("p2_pwm", 32'(pwm0), 32'd40);
        check_eq("p2_frac_pwm", 32'(pwm1), 32'd10);

        // Saturation at both rails
        do_clear();
        check_eq("clr_pwm", 32'(pwm0), 32'd0);
        run_update("sh", 8'd200, 1'b1, 8'd0, 8'd4, 8'd0, 8'd0);
        check_eq("sh_pwm", 32'(pwm0), 32'd255);
        check_eq("sh_sat_hi", 32'(hi0), 32'd1);
        check_eq("sh_sat_lo", 32'(lo0), 32'd0);
        tick(); tick();
        check_eq("sh_sat_hold", 32'(hi0), 32'd1);
        run_update("sl", 8'd10, 1'b1, 8'd200, 8'd1, 8'd0, 8'd0);
        check_eq("sl_pwm", 32'(pwm0), 32'd0);
        check_eq("sl_sat_lo", 32'(lo0), 32'd1);
        check_eq("sl_sat_hi", 32'(hi0), 32'd0);
        do_clear();
        check_eq("clr_sat_lo", 32'(lo0), 32'd0);

        // Integral only, held set point on the third sample
        run_update("i1", 8'd50, 1'b1, 8'd45, 8'd0, 8'd1, 8'd0);
        check_eq("i1_pwm", 32'(pwm0), 32'd5);
        run_update("i2", 8'd50, 1'b1, 8'd45, 8'd0, 8'd1, 8'd0);
        check_eq("i2_pwm", 32'(pwm0), 32'd10);
        run_update("i3", 8'd0, 1'b0, 8'd45, 8'd0, 8'd1, 8'd0);
        check_eq("i3_pwm", 32'(pwm0), 32'd15);
        check_eq("i3_frac_pwm", 32'(pwm1), 32'd3);

        // Fractional gain scaling with floor on negative delta
        do_clear();
        run_update("f1", 8'd7, 1'b1, 8'd0, 8'd1, 8'd0, 8'd0);
        check_eq("f1_frac_pwm", 32'(pwm1), 32'd1);
        check_eq("f1_frac_sat_lo", 32'(lo1), 32'd0);
        check_eq("f1_pwm", 32'(pwm0), 32'd7);
        run_update("f2", 8'd0, 1'b1, 8'd6, 8'd1, 8'd0, 8'd0);
        check_eq("f2_frac_pwm", 32'(pwm1), 32'd0);
        check_eq("f2_frac_sat_lo", 32'(lo1), 32'd1);
        check_eq("f2_pwm", 32'(pwm0), 32'd0);
        check_eq("f2_sat_lo", 32'(lo0), 32'd1);

        // Overrun: second SAMPLE mid-update and one coincident with DONE
        do_clear();
        SET_POINT = 8'd20; SP_VALID = 1'b1; ENC_VAL = 8'd0;
        KP = 8'd1; KI = 8'd0; KD = 8'd0;
        SAMPLE = 1'b1;
        tick();
        SAMPLE = 1'b0;
        tick();
        tick();
        SET_POINT = 8'd100;
        SAMPLE = 1'b1;
        tick();
        SAMPLE = 1'b0;
        check_eq("ovr_pulse", 32'(ovr0), 32'd1);
        check_eq("ovr_busy", 32'(busy0), 32'd1);
        tick();
        check_eq("ovr_pulse_end", 32'(ovr0), 32'd0);
        check_eq("ovr_no_early_done", 32'(done0), 32'd0);
        SAMPLE = 1'b1;
        tick();
        SAMPLE = 1'b0;
        check_eq("ovr_done", 32'(done0), 32'd1);
        check_eq("ovr_pwm", 32'(pwm0), 32'd20);
        check_eq("ovr_at_done", 32'(ovr0), 32'd1);
        tick();
        check_eq("ovr_single_done", 32'(done0), 32'd0);
        check_eq("ovr_not_queued", 32'(busy0), 32'd0);

        // CLEAR mid-update
        SET_POINT = 8'd50;
        SAMPLE = 1'b1;
        tick();
        SAMPLE = 1'b0;
        tick();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        check_eq("clr_mid_pwm", 32'(pwm0), 32'd0);
        tick();
        check_eq("clr_mid_busy", 32'(busy0), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | done0;
        end
        check_eq("clr_mid_no_done", 32'(seen), 32'd0);

        // RST mid-update, then behaviour as after power-up
        run_update("rs", 8'd255, 1'b1, 8'd0, 8'd2, 8'd0, 8'd0);
        check_eq("rs_pwm", 32'(pwm0), 32'd255);
        check_eq("rs_sat_hi", 32'(hi0), 32'd1);
        SET_POINT = 8'd10; KP = 8'd1; KI = 8'd0; KD = 8'd0;
        SAMPLE = 1'b1;
        tick();
        SAMPLE = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();
        check_eq("rmid_pwm", 32'(pwm0), 32'd0);
        check_eq("rmid_busy", 32'(busy0), 32'd0);
        check_eq("rmid_done", 32'(done0), 32'd0);
        check_eq("rmid_sat_hi", 32'(hi0), 32'd0);
        check_eq("rmid_overrun", 32'(ovr0), 32'd0);
        RST = 1'b1;
        tick();
        run_update("pu0", 8'd77, 1'b0, 8'd0, 8'd1, 8'd0, 8'd0);
        check_eq("pu0_pwm", 32'(pwm0), 32'd0);
        run_update("pu1", 8'd100, 1'b1, 8'd0, 8'd1, 8'd0, 8'd0);
        check_eq("pu1_pwm", 32'(pwm0), 32'd100);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/pid_rate_ctrl.md
# pid_rate_ctrl

Parametrised incremental (velocity-form) PID controller that closes the speed loop between the encoder sample path and the motor PWM stage. On each sample strobe it latches set point and encoder count, shifts a three-deep error history, and accumulates the PID delta with one shared multiplier. It then adds the delta to the held duty and clamps the result into the PWM range. Gains are runtime inputs rather than elaboration constants. Output saturation is symmetric at both rails, with status flags.

## Interface
- DW, 8, set-point / encoder width (unsigned)
- GW, 8, gain width (unsigned KP/KI/KD)
- OW, 8, duty output width
- OUT_MAX, 2**OW-1, upper clamp of duty
- FRAC, 0, arithmetic right shift applied to PID delta (fixed-point gains)
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- SAMPLE  in  1  one-cycle strobe: start a control update
- SP_VALID  in  1  SET_POINT is fresh; when low, last held set point is reused
- SET_POINT  in  DW  target speed
- ENC_VAL  in  DW  measured speed
- KP, KI, KD  in  GW each  gains, latched at SAMPLE acceptance
- CLEAR  in  1  zero error history and duty, abort in-flight update
- PWM_VAL  out  OW  duty to PWM stage
- DONE  out  1  one-cycle pulse, PWM_VAL just updated
- BUSY  out  1  update in progress
- SAT_HI, SAT_LO  out  1 each  last update clamped at OUT_MAX / 0
- OVERRUN  out  1  one-cycle pulse, SAMPLE arrived while BUSY

## Operation
- States: IDLE, CAPTURE, MAC0, MAC1, MAC2, UPDATE.
- IDLE: on SAMPLE, latch ENC_VAL, the gains, and SET_POINT if SP_VALID; go to CAPTURE.
- CAPTURE: e2<=e1, e1<=e0, e0<=sp_hold-enc (signed, DW+1 bits). Compute A=KP+KI+KD and B=KP+2*KD (GW+2 bits). Clear the accumulator.
- MAC0: acc+=A*e0. MAC1: acc-=B*e1. MAC2: acc+=KD*e2.
- Accumulator width is DW+GW+5 signed; no overflow is possible by construction.
- UPDATE: du=acc>>>FRAC (floor), u=PWM_VAL+du. If u<0, PWM_VAL=0 and SAT_LO=1. If u>OUT_MAX, PWM_VAL=OUT_MAX and SAT_HI=1. Otherwise PWM_VAL=u and both flags are 0. Pulse DONE and return to IDLE.
- SAT flags hold until the next UPDATE.
- SAMPLE outside IDLE is ignored and pulses OVERRUN; it is not queued.
- Priority: RST > CLEAR > SAMPLE.
- CLEAR zeroes e0..e2, PWM_VAL and the SAT flags, keeps sp_hold, and returns to IDLE without DONE.

## Timing
- Reset values: PWM_VAL=0, DONE=0, BUSY=0, SAT_HI=0, SAT_LO=0, OVERRUN=0, state IDLE. Reset also zeroes e0..e2, sp_hold and acc.
- SAMPLE accepted at edge T: BUSY high T+1..T+5; PWM_VAL and DONE change at edge T+5.
- Minimum accepted sample spacing is 6 cycles. SAMPLE at T+5, coincident with DONE, is treated as an overrun.
- RST or CLEAR mid-update: state IDLE next edge, no DONE, PWM_VAL not updated from acc (CLEAR zeroes it).
- SET_POINT, ENC_VAL and the gains are sampled only at acceptance; later changes do not affect the current update.

## Structure
- Shared package pid_pkg: state enum, localparam width helpers (err, coeff, acc widths), clamp function.
- Sub-module pid_mac: a single signed multiplier plus an add/subtract accumulator with clear, load and op-select. It is reused across MAC0..MAC2.
- Top block holds the FSM, history registers, set-point hold and clamp/flag logic.

## Test plan
- KP=1, KI=KD=0, SP=100 (valid), ENC=0 -> PWM_VAL=100 at T+5, DONE once. Then ENC=60 -> PWM_VAL=40.
- KP=4, SP=200, ENC=0 from PWM_VAL=0 -> PWM_VAL=255, SAT_HI=1. Next SP=10, ENC=200, KP=1 -> PWM_VAL=0, SAT_LO=1, SAT_HI=0.
- KP=0, KI=1, SP=50, ENC=45 constant, three samples -> PWM_VAL 5, 10, 15. SP_VALID=0 with SET_POINT=0 on the third sample still gives 15.
- FRAC=2, KP=1, SP=7, ENC=0 -> du=floor(7/4)=1, PWM_VAL=1. Then SP=0 (valid), ENC=6 -> du=floor(-13/4)=-4, clamped to 0, SAT_LO=1.
- SAMPLE at T and T+3 -> OVERRUN pulse at T+4 and a single DONE at T+5. CLEAR at T+2 of a new update -> no DONE, PWM_VAL=0, BUSY low at T+3.
- RST low at T+3 mid-update -> all outputs at reset values on the next edge, and the next SAMPLE behaves as the first after power-up.
